control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on rising edge.
REQ-002 SHALL have port clr, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port IR, input, 32, instruction register contents; opcode = IR[31:27].
REQ-004 SHALL have port CON, input, 1, branch-condition flag from the CON FF.
REQ-005 SHALL have outputs PCout, ZLowOut, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, MDRread, W_sig, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, each output 1 bit, datapath strobes driving the cpu_phase2 ports of the same names.
REQ-006 SHALL have port operation, output, 5, ALU op select.
REQ-007 SHALL have port run, output, 1, high while not halted.

Function
REQ-008 SHALL implement an FSM with states RST, T0..T7 and HALT, with a registered present-state.
REQ-009 Outputs SHALL be combinational in present state and IR[31:27] (Moore plus opcode decode); every strobe not listed for a state SHALL be 0 and operation SHALL be 00000.
REQ-010 Opcodes SHALL be: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, andi 01101, ori 01110, br 10010, nop 11010, halt 11011; every other opcode SHALL execute as nop.
REQ-011 operation SHALL equal the opcode for add/sub/and/or, and SHALL be 00011 for addi, ldi, ld, st and br, 00101 for andi, and 00110 for ori.
REQ-012 RST SHALL go to T0 on the first clk edge after clr is high.
REQ-013 Fetch SHALL be: T0 PCout MARin IncPC Zin; T1 ZLowOut PCin MDRread MDRin; T2 MDRout IRin; all go to the next T.
REQ-014 Reg ALU (add/sub/and/or) SHALL be: T3 Grb Rout Yin; T4 Grc Rout Zin operation; T5 ZLowOut Gra Rin; then T0.
REQ-015 Immediate (addi/andi/ori/ldi) SHALL be: T3 Grb BAout Yin; T4 Cout Zin operation; T5 ZLowOut Gra Rin; then T0.
REQ-016 ld SHALL be: T3–T4 as REQ-015; T5 ZLowOut MARin; T6 MDRread MDRin; T7 MDRout Gra Rin; then T0.
REQ-017 st SHALL be: T3–T5 as ld; T6 Gra Rout MDRin with MDRread=0; T7 W_sig; then T0.
REQ-018 br SHALL be: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin operation; T6 ZLowOut, and PCin=CON sampled combinationally in T6; then T0.
REQ-019 nop/undefined SHALL go T3 -> T0 with all strobes 0 in T3.
REQ-020 halt SHALL go T3 -> HALT with all strobes 0; HALT SHALL hold until clr low; run=0 only in HALT.
REQ-021 IR SHALL be treated as stable from T3 through the end of the instruction; opcode changes in T0–T2 SHALL NOT affect sequencing.
REQ-022 Instruction length SHALL be 6 cycles (ALU/imm/ldi), 8 cycles (ld/st), 7 cycles (br), or 4 cycles (nop), counted T0 to the last T inclusive.

Reset
REQ-023 clr low SHALL force state to RST immediately, independent of clk, including mid-instruction.
REQ-024 In RST all strobes SHALL be 0, operation SHALL be 00000, and run SHALL be 1.
REQ-025 A write strobe (Rin, W_sig, PCin, MDRin) SHALL NOT glitch high on reset assertion or deassertion.

Verification
REQ-026 Bench SHALL cover addi: clr low then high, IR=0x6088000A (addi) -> T0–T2 fetch strobes; T3 Grb=BAout=Yin=1; T4 Cout=Zin=1, operation=00011; T5 ZLowOut=Gra=Rin=1; T0 on cycle 7.
REQ-027 Bench SHALL cover ld: IR opcode 00000 -> T5 MARin=1; T6 MDRread=MDRin=1; T7 Gra=Rin=MDRout=1; then T0; total 8 cycles.
REQ-028 Bench SHALL cover br with CON=0 and then CON=1 -> T6 PCin=0 and 1 respectively, ZLowOut=1 in both.
REQ-029 Bench SHALL cover halt: opcode 11011 -> HALT after T3, run=0, no strobes for 20 cycles; clr pulse low -> RST, run=1, then T0.
REQ-030 Bench SHALL cover reset mid-store: clr low during T6 of st -> all strobes 0 immediately, W_sig never asserted, restart at T0.
REQ-031 Bench SHALL cover undefined opcode 11111 -> T3 with all strobes 0, then T0 (4-cycle nop).

Source files
------------

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//   Hardwired sequencer for the phase-2 CPU datapath. A registered FSM steps
//   through RST, T0..T7 and HALT. Every datapath strobe is decoded
//   combinationally from the present state and the opcode in IR[31:27].
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   clr        asynchronous active-low reset; forces the FSM to RST
//   IR         instruction register contents; opcode = IR[31:27]
//   CON        branch-condition flag from the CON flip-flop
//   PCout ..   one-bit datapath strobes, named after the cpu_phase2 ports
//   CONin      they drive
//   operation  ALU operation select
//   run        high in every state except HALT
// ---------------------------------------------------------------------------
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON,
    output logic        PCout,
    output logic        ZLowOut,
    output logic        MDRout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        IncPC,
    output logic        MDRread,
    output logic        W_sig,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        CONin,
    output logic [4:0]  operation,
    output logic        run
);

    typedef enum logic [3:0] {
        RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     state, state_nxt;
    logic [4:0] opcode;
    logic       is_alu, is_imm, is_ld, is_st, is_br, is_halt;
    logic [4:0] alu_op;

    assign opcode = IR[31:27];

    // Instruction class decode. Anything not matched here, including the
    // explicit nop encoding, falls through to the nop path.
    always_comb begin
        is_alu  = 1'b0;
        is_imm  = 1'b0;
        is_ld   = 1'b0;
        is_st   = 1'b0;
        is_br   = 1'b0;
        is_halt = 1'b0;
        alu_op  = 5'b00000;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                is_alu = 1'b1;
                alu_op = opcode;
            end
            OP_ADDI, OP_LDI: begin
                is_imm = 1'b1;
                alu_op = OP_ADD;
            end
            OP_ANDI: begin
                is_imm = 1'b1;
                alu_op = OP_AND;
            end
            OP_ORI: begin
                is_imm = 1'b1;
                alu_op = OP_OR;
            end
            OP_LD: begin
                is_ld  = 1'b1;
                alu_op = OP_ADD;
            end
            OP_ST: begin
                is_st  = 1'b1;
                alu_op = OP_ADD;
            end
            OP_BR: begin
                is_br  = 1'b1;
                alu_op = OP_ADD;
            end
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

    // While clr is low the register is held in RST, so RST always moves to
    // T0 on the first edge that sees clr high. Because every strobe is zero
    // in RST, asserting clr drives all write strobes low directly.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= RST;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = T0;
        case (state)
            RST:  state_nxt = T0;
            T0:   state_nxt = T1;
            T1:   state_nxt = T2;
            T2:   state_nxt = T3;
            T3: begin
                if (is_halt)
                    state_nxt = HALT;
                else if (is_alu || is_imm || is_ld || is_st || is_br)
                    state_nxt = T4;
                else
                    state_nxt = T0;
            end
            T4:   state_nxt = T5;
            T5:   state_nxt = (is_ld || is_st || is_br) ? T6 : T0;
            T6:   state_nxt = (is_ld || is_st) ? T7 : T0;
            T7:   state_nxt = T0;
            HALT: state_nxt = HALT;
            default: state_nxt = RST;
        endcase
    end

    always_comb begin
        PCout     = 1'b0;
        ZLowOut   = 1'b0;
        MDRout    = 1'b0;
        MARin     = 1'b0;
        Zin       = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        IncPC     = 1'b0;
        MDRread   = 1'b0;
        W_sig     = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        Rin       = 1'b0;
        Rout      = 1'b0;
        BAout     = 1'b0;
        Cout      = 1'b0;
        CONin     = 1'b0;
        operation = 5'b00000;
        run       = (state != HALT);
        case (state)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                ZLowOut = 1'b1;
                PCin    = 1'b1;
                MDRread = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (is_alu) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (is_imm || is_ld || is_st) begin
                    Grb   = 1'b1;
                    BAout = 1'b1;
                    Yin   = 1'b1;
                end else if (is_br) begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    CONin = 1'b1;
                end
            end
            T4: begin
                if (is_alu) begin
                    Grc       = 1'b1;
                    Rout      = 1'b1;
                    Zin       = 1'b1;
                    operation = alu_op;
                end else if (is_imm || is_ld || is_st) begin
                    Cout      = 1'b1;
                    Zin       = 1'b1;
                    operation = alu_op;
                end else if (is_br) begin
                    PCout = 1'b1;
                    Yin   = 1'b1;
                end
            end
            T5: begin
                if (is_alu || is_imm) begin
                    ZLowOut = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end else if (is_ld || is_st) begin
                    ZLowOut = 1'b1;
                    MARin   = 1'b1;
                end else if (is_br) begin
                    Cout      = 1'b1;
                    Zin       = 1'b1;
                    operation = alu_op;
                end
            end
            T6: begin
                if (is_ld) begin
                    MDRread = 1'b1;
                    MDRin   = 1'b1;
                end else if (is_st) begin
                    // Store data comes from the register file, not memory.
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    MDRin = 1'b1;
                end else if (is_br) begin
                    // Branch target is written only when the condition holds.
                    ZLowOut = 1'b1;
                    PCin    = CON;
                end
            end
            T7: begin
                if (is_ld) begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end else if (is_st) begin
                    W_sig = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//   Directed bench for control_unit. The stimulus process pushes the expected
//   output word for every cycle into a queue; a monitor pops and compares at
//   each falling clock edge, or immediately when an asynchronous event is
//   checked mid-cycle.
// ---------------------------------------------------------------------------
module tb_control_unit;

    logic        clk;
    logic        clr;
    logic [31:0] IR;
    logic        CON;
    logic PCout, ZLowOut, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC;
    logic MDRread, W_sig, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin;
    logic [4:0]  operation;
    logic        run;

    control_unit dut (
        .clk(clk), .clr(clr), .IR(IR), .CON(CON),
        .PCout(PCout), .ZLowOut(ZLowOut), .MDRout(MDRout), .MARin(MARin),
        .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .IncPC(IncPC), .MDRread(MDRread), .W_sig(W_sig), .Gra(Gra),
        .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .CONin(CONin), .operation(operation), .run(run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe bit masks, ordered as in the packed observation word.
    localparam logic [19:0] PCOUT = 20'h80000;
    localparam logic [19:0] ZLO   = 20'h40000;
    localparam logic [19:0] MDRO  = 20'h20000;
    localparam logic [19:0] MARIN = 20'h10000;
    localparam logic [19:0] ZIN   = 20'h08000;
    localparam logic [19:0] PCIN  = 20'h04000;
    localparam logic [19:0] MDRIN = 20'h02000;
    localparam logic [19:0] IRIN  = 20'h01000;
    localparam logic [19:0] YIN   = 20'h00800;
    localparam logic [19:0] INCPC = 20'h00400;
    localparam logic [19:0] MDRRD = 20'h00200;
    localparam logic [19:0] WSIG  = 20'h00100;
    localparam logic [19:0] GRA   = 20'h00080;
    localparam logic [19:0] GRB   = 20'h00040;
    localparam logic [19:0] GRC   = 20'h00020;
    localparam logic [19:0] RIN   = 20'h00010;
    localparam logic [19:0] ROUT  = 20'h00008;
    localparam logic [19:0] BAOUT = 20'h00004;
    localparam logic [19:0] COUT  = 20'h00002;
    localparam logic [19:0] CONIN = 20'h00001;
    localparam logic [19:0] NONE  = 20'h00000;

    typedef struct {
        string       name;
        logic [25:0] vec;
    } exp_t;

    exp_t  sb[$];
    event  chk_ev;
    int    n_chk  = 0;
    int    n_fail = 0;
    logic  done   = 1'b0;

    wire [25:0] act = {PCout, ZLowOut, MDRout, MARin, Zin, PCin, MDRin, IRin,
                       Yin, IncPC, MDRread, W_sig, Gra, Grb, Grc, Rin, Rout,
                       BAout, Cout, CONin, operation, run};

    // Monitor: one expectation is consumed per observation point.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk or chk_ev);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_chk++;
                if (act !== e.vec) begin
                    n_fail++;
                    $display("FAIL %s: got strobes=%05h op=%05b run=%b, want strobes=%05h op=%05b run=%b",
                             e.name, act[25:6], act[5:1], act[0],
                             e.vec[25:6], e.vec[5:1], e.vec[0]);
                end
            end
        end
    end

    task automatic expect_now(input string nm, input logic [19:0] s,
                              input logic [4:0] op = 5'b00000,
                              input logic r = 1'b1);
        exp_t e;
        e.name = nm;
        e.vec  = {s, op, r};
        sb.push_back(e);
    endtask

    task automatic step(input string nm, input logic [19:0] s,
                        input logic [4:0] op = 5'b00000,
                        input logic r = 1'b1);
        @(posedge clk);
        #1;
        expect_now(nm, s, op, r);
    endtask

    task automatic release_clr();
        @(negedge clk);
        #2 clr = 1'b1;
    endtask

    // IR is loaded right after the edge into T0; the FSM only looks at it
    // from T3 on.
    task automatic fetch(input string tag, input logic [31:0] ir, input logic c);
        @(posedge clk);
        #1;
        IR  = ir;
        CON = c;
        expect_now({tag, "_T0"}, PCOUT | MARIN | INCPC | ZIN);
        step({tag, "_T1"}, ZLO | PCIN | MDRRD | MDRIN);
        step({tag, "_T2"}, MDRO | IRIN);
    endtask

    task automatic alu_instr(input string tag, input logic [31:0] ir, input logic [4:0] op);
        fetch(tag, ir, 1'b0);
        step({tag, "_T3"}, GRB | ROUT | YIN);
        step({tag, "_T4"}, GRC | ROUT | ZIN, op);
        step({tag, "_T5"}, ZLO | GRA | RIN);
    endtask

    task automatic imm_instr(input string tag, input logic [31:0] ir, input logic [4:0] op);
        fetch(tag, ir, 1'b0);
        step({tag, "_T3"}, GRB | BAOUT | YIN);
        step({tag, "_T4"}, COUT | ZIN, op);
        step({tag, "_T5"}, ZLO | GRA | RIN);
    endtask

    task automatic br_instr(input string tag, input logic c);
        fetch(tag, 32'h9000_0000, c);
        step({tag, "_T3"}, GRA | ROUT | CONIN);
        step({tag, "_T4"}, PCOUT | YIN);
        step({tag, "_T5"}, COUT | ZIN, 5'b00011);
        step({tag, "_T6"}, c ? (ZLO | PCIN) : ZLO);
    endtask

    initial begin
        clr = 1'b0;
        IR  = 32'h0;
        CON = 1'b0;

        // Reset state, before and across a clock edge.
        #2;
        expect_now("reset_async", NONE);
        -> chk_ev;
        step("reset_held", NONE);
        release_clr();

        // addi: 6-cycle instruction; the next fetch lands on cycle 7.
        imm_instr("addi", 32'h6088_000A, 5'b00011);

        // ld: 8 cycles.
        fetch("ld", 32'h0080_0005, 1'b0);
        step("ld_T3", GRB | BAOUT | YIN);
        step("ld_T4", COUT | ZIN, 5'b00011);
        step("ld_T5", ZLO | MARIN);
        step("ld_T6", MDRRD | MDRIN);
        step("ld_T7", MDRO | GRA | RIN);

        // Register ALU ops and remaining immediates.
        alu_instr("add", 32'h1800_0000, 5'b00011);
        alu_instr("sub", 32'h2000_0000, 5'b00100);
        alu_instr("and", 32'h2800_0000, 5'b00101);
        alu_instr("or",  32'h3000_0000, 5'b00110);
        imm_instr("ldi",  32'h0800_0000, 5'b00011);
        imm_instr("andi", 32'h6800_0000, 5'b00101);
        imm_instr("ori",  32'h7000_0000, 5'b00110);

        // Branch not taken, then taken.
        br_instr("br_con0", 1'b0);
        br_instr("br_con1", 1'b1);

        // Undefined opcode and explicit nop: 4 cycles each.
        fetch("undef", 32'hF800_0000, 1'b0);
        step("undef_T3", NONE);
        fetch("nop", 32'hD000_0000, 1'b0);
        step("nop_T3", NONE);

        // Store interrupted by reset during T6.
        fetch("st", 32'h1000_0000, 1'b0);
        step("st_T3", GRB | BAOUT | YIN);
        step("st_T4", COUT | ZIN, 5'b00011);
        step("st_T5", ZLO | MARIN);
        step("st_T6", GRA | ROUT | MDRIN);
        @(negedge clk);
        #2 clr = 1'b0;
        #1;
        expect_now("st_reset_async", NONE);
        -> chk_ev;
        step("st_reset_held", NONE);
        release_clr();

        // Halt: stays put with run low until clr is pulsed.
        fetch("halt", 32'hD800_0000, 1'b0);
        step("halt_T3", NONE);
        for (int i = 0; i < 20; i++) step("halt_hold", NONE, 5'b00000, 1'b0);
        @(negedge clk);
        #2 clr = 1'b0;
        #1;
        expect_now("halt_clr", NONE);
        -> chk_ev;
        #1 clr = 1'b1;

        // Recovery after halt, followed by a complete instruction.
        imm_instr("post_halt_addi", 32'h6088_000A, 5'b00011);
        fetch("final", 32'hD000_0000, 1'b0);

        @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
